// File: rtl/axi_burst_master_if.sv
// Bundle of the command port, the five AXI channels and the local source/sink
// RAM ports used by axi_burst_master.
interface axi_burst_master_if #(
    parameter int DATA_SIZE  = 16,
    parameter int LADDR_SIZE = 13
);
    logic                  cmd_valid, cmd_ready, cmd_write;
    logic [31:0]           cmd_addr;
    logic [7:0]            cmd_len;
    logic [LADDR_SIZE-1:0] cmd_laddr;

    logic [31:0]           awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid, awready;

    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    logic                  wlast, wvalid, wready;

    logic [1:0]            bresp;
    logic                  bvalid, bready;

    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid, arready;

    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast, rvalid, rready;

    logic [LADDR_SIZE-1:0] src_addr;
    logic [DATA_SIZE-1:0]  src_data;
    logic                  snk_wr;
    logic [LADDR_SIZE-1:0] snk_addr;
    logic [DATA_SIZE-1:0]  snk_data;
    logic                  done, err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_laddr,
        output cmd_ready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output src_addr,
        input  src_data,
        output snk_wr, snk_addr, snk_data, done, err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_laddr,
        input  cmd_ready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  src_addr,
        output src_data,
        input  snk_wr, snk_addr, snk_data, done, err
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI INCR burst master moving 16-bit samples between a
// local RAM and a 64-bit AXI bus (write: RAM -> AXI, read: AXI -> RAM).
module axi_burst_master #(
    parameter int DATA_SIZE  = 16,
    parameter int LADDR_SIZE = 13
) (
    input  logic               a_clk,
    input  logic               a_rst_n,
    axi_burst_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, W_ADDR, W_FETCH, W_DATA, W_RESP, R_ADDR, R_DATA, DONE
    } state_t;

    state_t                state;
    logic [31:0]           addr_q;
    logic [7:0]            len_q, beat;
    logic [LADDR_SIZE-1:0] laddr_q;
    logic [15:0]           samp_q;
    logic                  fetched;
    logic                  cmd_ready_q, awvalid_q, wvalid_q, bready_q;
    logic                  arvalid_q, rready_q, done_q, err_q;

    logic [31:0]           baddr;
    logic [1:0]            lane;
    logic                  last_beat;
    logic [15:0]           w_sample, r_sample;

    // Byte address of the current beat selects the 16-bit lane of the 64-bit bus.
    assign baddr     = addr_q + {23'd0, beat, 1'b0};
    assign lane      = baddr[2:1];
    assign last_beat = (beat == len_q);
    // RAM data is live in the first W_DATA cycle, then held locally for stalls.
    assign w_sample  = fetched ? samp_q : 16'(bus.src_data);
    assign r_sample  = bus.rdata[{lane, 4'b0} +: 16];

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.awaddr    = addr_q;
    assign bus.awlen     = len_q;
    assign bus.awsize    = 3'b001;
    assign bus.awburst   = 2'b01;
    assign bus.awvalid   = awvalid_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.wdata     = wvalid_q ? (64'(w_sample) << {lane, 4'b0}) : 64'd0;
    assign bus.wstrb     = wvalid_q ? (8'h03 << {lane, 1'b0}) : 8'd0;
    assign bus.wlast     = wvalid_q && last_beat;
    assign bus.bready    = bready_q;
    assign bus.araddr    = addr_q;
    assign bus.arlen     = len_q;
    assign bus.arsize    = 3'b001;
    assign bus.arburst   = 2'b01;
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;
    assign bus.src_addr  = laddr_q + LADDR_SIZE'(beat);
    assign bus.snk_wr    = rready_q && bus.rvalid;
    assign bus.snk_addr  = laddr_q + LADDR_SIZE'(beat);
    assign bus.snk_data  = DATA_SIZE'(r_sample);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            laddr_q     <= '0;
            beat        <= '0;
            samp_q      <= '0;
            fetched     <= 1'b0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= bus.cmd_addr;
                        len_q       <= bus.cmd_len;
                        laddr_q     <= bus.cmd_laddr;
                        beat        <= '0;
                        err_q       <= 1'b0;
                        if (bus.cmd_write) begin
                            awvalid_q <= 1'b1;
                            state     <= W_ADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= R_ADDR;
                        end
                    end
                end
                W_ADDR: if (bus.awready) begin
                    awvalid_q <= 1'b0;
                    state     <= W_FETCH;
                end
                W_FETCH: begin
                    wvalid_q <= 1'b1;
                    state    <= W_DATA;
                end
                W_DATA: begin
                    fetched <= 1'b1;
                    if (!fetched) samp_q <= 16'(bus.src_data);
                    if (bus.wready) begin
                        wvalid_q <= 1'b0;
                        fetched  <= 1'b0;
                        if (last_beat) begin
                            bready_q <= 1'b1;
                            state    <= W_RESP;
                        end else begin
                            beat  <= beat + 8'd1;
                            state <= W_FETCH;
                        end
                    end
                end
                W_RESP: if (bus.bvalid) begin
                    bready_q <= 1'b0;
                    err_q    <= (bus.bresp != 2'b00);
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                R_ADDR: if (bus.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= R_DATA;
                end
                R_DATA: if (bus.rvalid) begin
                    // A premature or missing rlast is an error and also ends the burst.
                    if (bus.rresp != 2'b00 || bus.rlast != last_beat) err_q <= 1'b1;
                    if (bus.rlast || last_beat) begin
                        rready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        beat <= beat + 8'd1;
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: acts as AXI slave and local RAMs,
// and checks every beat against a transaction-level model of the burst rules.
module tb_axi_burst_master;
    localparam int DS = 16, LS = 13, DEPTH = 1 << LS;

    logic a_clk = 1'b0;
    logic a_rst_n = 1'b0;
    always #5 a_clk = ~a_clk;

    axi_burst_master_if #(.DATA_SIZE(DS), .LADDR_SIZE(LS)) bus();
    axi_burst_master #(.DATA_SIZE(DS), .LADDR_SIZE(LS)) dut (
        .a_clk(a_clk), .a_rst_n(a_rst_n), .bus(bus)
    );

    logic [15:0] mem [DEPTH];
    always @(posedge a_clk) bus.src_data <= mem[bus.src_addr];

    int n_chk = 0, n_fail = 0;

    int          got_done, timeout, aw_cnt, ar_cnt;
    logic        got_err, done_after, cr_after, err_after;
    logic [31:0] ax_addr;
    logic [7:0]  ax_len;
    logic [2:0]  ax_size;
    logic [1:0]  ax_burst;
    logic [63:0] wb_data[$];
    logic [7:0]  wb_strb[$];
    logic        wb_last[$];
    logic [63:0] wc_data[$];
    logic [7:0]  wc_strb[$];
    logic        wc_rdy[$];
    logic [LS-1:0] sk_addr[$];
    logic [15:0] sk_data[$];
    logic [63:0] rsent[$];

    // Model: lane = bits [2:1] of the beat byte address addr + 2*beat.
    function automatic int exp_lane(input logic [31:0] a, input int b);
        logic [31:0] ba;
        ba = a + 32'(2 * b);
        return int'((ba / 2) % 4);
    endfunction

    function automatic logic [LS-1:0] exp_laddr(input logic [LS-1:0] la, input int b);
        return LS'((int'(la) + b) % DEPTH);
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_len = 0; bus.cmd_laddr = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.arready = 0;
        bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
    endtask

    task automatic clear_results();
        got_done = 0; timeout = 0; aw_cnt = 0; ar_cnt = 0;
        got_err = 0; done_after = 0; cr_after = 0; err_after = 0;
        ax_addr = 0; ax_len = 0; ax_size = 0; ax_burst = 0;
        wb_data.delete(); wb_strb.delete(); wb_last.delete();
        wc_data.delete(); wc_strb.delete(); wc_rdy.delete();
        sk_addr.delete(); sk_data.delete(); rsent.delete();
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l, input logic [LS-1:0] la);
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) begin @(posedge a_clk); #1; end
        if (!bus.cmd_ready) begin timeout = 1; return; end
        bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_laddr = la; bus.cmd_valid = 1;
        @(posedge a_clk); #1;
        bus.cmd_valid = 0;
    endtask

    task automatic finish_done();
        got_done++; got_err = bus.err; idle_inputs();
        @(posedge a_clk); #1;
        done_after = bus.done; cr_after = bus.cmd_ready; err_after = bus.err;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [7:0] l, input logic [LS-1:0] la,
                               input bit rnd, input int stall_beat, input int stall_cyc,
                               input logic [1:0] resp, input int abort_beat);
        int beats, stall_left;
        bit b_done;
        clear_results();
        issue(1'b1, a, l, la);
        if (timeout != 0) return;
        beats = 0; stall_left = stall_cyc; b_done = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (bus.done) begin finish_done(); return; end
            bus.awready = rnd ? 1'($urandom) : 1'b1;
            if (bus.awvalid && bus.awready) begin
                aw_cnt++; ax_addr = bus.awaddr; ax_len = bus.awlen; ax_size = bus.awsize; ax_burst = bus.awburst;
            end
            bus.bresp  = resp;
            bus.bvalid = (beats > int'(l) && !b_done) && (rnd ? 1'($urandom) : 1'b1);
            if (bus.bvalid && bus.bready) b_done = 1;
            if (bus.wvalid) begin
                if (beats == abort_beat) begin bus.wready = 0; return; end
                if (beats == stall_beat && stall_left > 0) begin bus.wready = 0; stall_left--; end
                else bus.wready = rnd ? 1'($urandom) : 1'b1;
                wc_data.push_back(bus.wdata); wc_strb.push_back(bus.wstrb); wc_rdy.push_back(bus.wready);
                if (bus.wready) begin
                    wb_data.push_back(bus.wdata); wb_strb.push_back(bus.wstrb); wb_last.push_back(bus.wlast);
                    beats++;
                end
            end else bus.wready = 0;
            @(posedge a_clk); #1;
        end
        timeout = 1; idle_inputs();
    endtask

    task automatic drive_read(input logic [31:0] a, input logic [7:0] l, input logic [LS-1:0] la,
                              input bit rnd, input int rlast_at, input int bad_beat);
        int k;
        bit ar_done;
        clear_results();
        issue(1'b0, a, l, la);
        if (timeout != 0) return;
        k = 0; ar_done = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (bus.done) begin finish_done(); return; end
            bus.arready = rnd ? 1'($urandom) : 1'b1;
            if (bus.arvalid && bus.arready) begin
                ar_cnt++; ax_addr = bus.araddr; ax_len = bus.arlen; ax_size = bus.arsize; ax_burst = bus.arburst;
            end
            bus.rvalid = ar_done && (rnd ? 1'($urandom) : 1'b1);
            bus.rdata  = {$urandom, $urandom};
            bus.rlast  = (k == rlast_at);
            bus.rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
            #1;
            if (bus.snk_wr) begin sk_addr.push_back(bus.snk_addr); sk_data.push_back(bus.snk_data); end
            if (bus.rvalid && bus.rready) begin rsent.push_back(bus.rdata); k++; end
            if (bus.arvalid && bus.arready) ar_done = 1;
            @(posedge a_clk); #1;
        end
        timeout = 1; idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        a_rst_n = 0;
        repeat (3) @(posedge a_clk);
        #1;
        n_chk++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
        n_chk++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.done, bus.err, bus.snk_wr, bus.wlast} !== 9'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.done, bus.err, bus.snk_wr, bus.wlast});
        end
        n_chk++;
        if ({bus.awaddr, bus.araddr, bus.awlen, bus.arlen, bus.wstrb, bus.wdata, bus.src_addr, bus.snk_addr} !== '0) begin
            n_fail++; $display("FAIL reset_buses: got nonzero awaddr=%h wstrb=%h wdata=%h src_addr=%h", bus.awaddr, bus.wstrb, bus.wdata, bus.src_addr);
        end
        @(negedge a_clk); a_rst_n = 1;
        @(posedge a_clk); #1;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_write_basic();
        logic [31:0] a = 32'h0;
        logic [7:0]  l = 8'd3;
        logic [LS-1:0] la = LS'(16'h10);
        drive_write(a, l, la, 1'b0, -1, 0, 2'b00, -1);
        n_chk++; if (timeout != 0) begin n_fail++; $display("FAIL wr_basic_timeout: got %0d want 0", timeout); end
        n_chk++; if (aw_cnt != 1) begin n_fail++; $display("FAIL wr_basic_aw_count: got %0d want 1", aw_cnt); end
        n_chk++;
        if ({ax_addr, ax_len, ax_size, ax_burst} !== {a, l, 3'b001, 2'b01}) begin
            n_fail++; $display("FAIL wr_basic_aw: got addr=%h len=%0d size=%b burst=%b want %h/%0d/001/01", ax_addr, ax_len, ax_size, ax_burst, a, l);
        end
        n_chk++; if (wb_data.size() != 4) begin n_fail++; $display("FAIL wr_basic_beats: got %0d want 4", wb_data.size()); end
        for (int b = 0; b < wb_data.size() && b < 4; b++) begin
            logic [63:0] ed = 64'(mem[exp_laddr(la, b)]) << (16 * exp_lane(a, b));
            logic [7:0]  es = 8'(3 << (2 * exp_lane(a, b)));
            n_chk++; if (wb_data[b] !== ed) begin n_fail++; $display("FAIL wr_basic_data beat %0d: got %h want %h", b, wb_data[b], ed); end
            n_chk++; if (wb_strb[b] !== es) begin n_fail++; $display("FAIL wr_basic_strb beat %0d: got %h want %h", b, wb_strb[b], es); end
            n_chk++; if (wb_last[b] !== (b == 3)) begin n_fail++; $display("FAIL wr_basic_last beat %0d: got %b want %b", b, wb_last[b], b == 3); end
        end
        n_chk++; if (got_done != 1 || got_err !== 1'b0) begin n_fail++; $display("FAIL wr_basic_done: got done=%0d err=%b want 1/0", got_done, got_err); end
        n_chk++; if (done_after !== 1'b0 || cr_after !== 1'b1) begin n_fail++; $display("FAIL wr_basic_after: got done=%b cmd_ready=%b want 0/1", done_after, cr_after); end
    endtask

    task automatic test_read_basic();
        logic [31:0] a = 32'h4002;
        logic [LS-1:0] la = '0;
        drive_read(a, 8'd1, la, 1'b0, 1, -1);
        n_chk++; if (timeout != 0) begin n_fail++; $display("FAIL rd_basic_timeout: got %0d want 0", timeout); end
        n_chk++;
        if (ar_cnt != 1 || {ax_addr, ax_len, ax_size, ax_burst} !== {a, 8'd1, 3'b001, 2'b01}) begin
            n_fail++; $display("FAIL rd_basic_ar: got cnt=%0d addr=%h len=%0d size=%b burst=%b", ar_cnt, ax_addr, ax_len, ax_size, ax_burst);
        end
        n_chk++; if (sk_data.size() != 2) begin n_fail++; $display("FAIL rd_basic_writes: got %0d want 2", sk_data.size()); end
        for (int b = 0; b < sk_data.size() && b < 2 && b < rsent.size(); b++) begin
            logic [63:0] w = rsent[b];
            logic [15:0] ed = 16'(w >> (16 * (b + 1)));
            n_chk++; if (sk_addr[b] !== LS'(b)) begin n_fail++; $display("FAIL rd_basic_addr %0d: got %h want %h", b, sk_addr[b], b); end
            n_chk++; if (sk_data[b] !== ed) begin n_fail++; $display("FAIL rd_basic_data %0d: got %h want %h", b, sk_data[b], ed); end
        end
        n_chk++; if (got_done != 1 || got_err !== 1'b0) begin n_fail++; $display("FAIL rd_basic_done: got done=%0d err=%b want 1/0", got_done, got_err); end
    endtask

    task automatic test_write_stall();
        logic [31:0] a = 32'h6;
        logic [LS-1:0] la = LS'(DEPTH - 1);
        int stalls;
        drive_write(a, 8'd1, la, 1'b0, 1, 3, 2'b00, -1);
        n_chk++; if (timeout != 0) begin n_fail++; $display("FAIL stall_timeout: got %0d want 0", timeout); end
        n_chk++; if (wb_data.size() != 2) begin n_fail++; $display("FAIL stall_beats: got %0d want 2", wb_data.size()); end
        for (int b = 0; b < wb_data.size() && b < 2; b++) begin
            logic [63:0] ed = 64'(mem[exp_laddr(la, b)]) << (16 * exp_lane(a, b));
            n_chk++; if (wb_data[b] !== ed) begin n_fail++; $display("FAIL stall_data beat %0d: got %h want %h", b, wb_data[b], ed); end
            n_chk++; if (wb_last[b] !== (b == 1)) begin n_fail++; $display("FAIL stall_last beat %0d: got %b want %b", b, wb_last[b], b == 1); end
        end
        stalls = 0;
        for (int i = 0; i + 1 < wc_rdy.size(); i++) begin
            if (!wc_rdy[i]) begin
                stalls++;
                n_chk++;
                if (wc_data[i+1] !== wc_data[i] || wc_strb[i+1] !== wc_strb[i]) begin
                    n_fail++; $display("FAIL stall_stable cycle %0d: got %h/%h want %h/%h", i, wc_data[i+1], wc_strb[i+1], wc_data[i], wc_strb[i]);
                end
            end
        end
        n_chk++; if (stalls != 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", stalls); end
        n_chk++; if (got_done != 1 || got_err !== 1'b0) begin n_fail++; $display("FAIL stall_done: got done=%0d err=%b want 1/0", got_done, got_err); end
    endtask

    task automatic test_errors();
        drive_read(32'h100, 8'd3, LS'(32), 1'b0, 1, -1);
        n_chk++; if (sk_data.size() != 2) begin n_fail++; $display("FAIL early_rlast_writes: got %0d want 2", sk_data.size()); end
        n_chk++; if (got_done != 1 || got_err !== 1'b1) begin n_fail++; $display("FAIL early_rlast_err: got done=%0d err=%b want 1/1", got_done, got_err); end
        n_chk++; if (err_after !== 1'b1) begin n_fail++; $display("FAIL err_hold: got %b want 1", err_after); end
        drive_read(32'h180, 8'd1, LS'(40), 1'b0, 5, -1);
        n_chk++; if (sk_data.size() != 2 || got_err !== 1'b1) begin n_fail++; $display("FAIL missing_rlast: got writes=%0d err=%b want 2/1", sk_data.size(), got_err); end
        drive_read(32'h300, 8'd2, LS'(64), 1'b0, 2, 1);
        n_chk++; if (sk_data.size() != 3 || got_err !== 1'b1) begin n_fail++; $display("FAIL rresp_err: got writes=%0d err=%b want 3/1", sk_data.size(), got_err); end
        drive_write(32'h200, 8'd1, LS'(48), 1'b0, -1, 0, 2'b10, -1);
        n_chk++; if (wb_data.size() != 2 || got_done != 1 || got_err !== 1'b1) begin
            n_fail++; $display("FAIL bresp_err: got beats=%0d done=%0d err=%b want 2/1/1", wb_data.size(), got_done, got_err);
        end
        drive_read(32'h400, 8'd0, LS'(80), 1'b0, 0, -1);
        n_chk++; if (sk_data.size() != 1 || got_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got writes=%0d err=%b want 1/0", sk_data.size(), got_err); end
    endtask

    task automatic test_reset_midburst();
        logic [LS-1:0] la = LS'(96);
        drive_write(32'h0, 8'd3, LS'(90), 1'b0, -1, 0, 2'b00, 2);
        n_chk++; if (timeout != 0 || wb_data.size() != 2 || bus.wvalid !== 1'b1) begin
            n_fail++; $display("FAIL midburst_setup: got timeout=%0d beats=%0d wvalid=%b want 0/2/1", timeout, wb_data.size(), bus.wvalid);
        end
        #1 a_rst_n = 0;
        #1;
        n_chk++; if ({bus.wvalid, bus.cmd_ready, bus.done} !== 3'b000) begin
            n_fail++; $display("FAIL midburst_async: got wvalid/cmd_ready/done=%b want 000", {bus.wvalid, bus.cmd_ready, bus.done});
        end
        @(negedge a_clk); a_rst_n = 1;
        @(posedge a_clk); #1;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midburst_ready: got %b want 1", bus.cmd_ready); end
        drive_write(32'h12, 8'd0, la, 1'b0, -1, 0, 2'b00, -1);
        n_chk++; if (wb_data.size() != 1) begin n_fail++; $display("FAIL len0_beats: got %0d want 1", wb_data.size()); end
        if (wb_data.size() >= 1) begin
            logic [63:0] ed = 64'(mem[la]) << (16 * exp_lane(32'h12, 0));
            n_chk++; if (wb_data[0] !== ed || wb_last[0] !== 1'b1) begin
                n_fail++; $display("FAIL len0_beat: got %h last=%b want %h last=1", wb_data[0], wb_last[0], ed);
            end
        end
        n_chk++; if (got_done != 1 || got_err !== 1'b0) begin n_fail++; $display("FAIL len0_done: got done=%0d err=%b want 1/0", got_done, got_err); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0] l;
        logic [LS-1:0] la;
        logic [1:0] resp;
        int rl, bad, n;
        logic eerr;
        for (int it = 0; it < 30; it++) begin
            a  = $urandom & 32'hFFFF_FFFE;
            l  = 8'($urandom_range(0, 12));
            la = (it % 2 == 0) ? LS'(DEPTH - $urandom_range(1, 6)) : LS'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                drive_write(a, l, la, 1'b1, -1, 0, resp, -1);
                n_chk++; if (timeout != 0 || wb_data.size() != int'(l) + 1) begin
                    n_fail++; $display("FAIL rnd_wr_beats it %0d: got %0d timeout=%0d want %0d", it, wb_data.size(), timeout, int'(l) + 1);
                end
                for (int b = 0; b < wb_data.size() && b <= int'(l); b++) begin
                    logic [63:0] ed = 64'(mem[exp_laddr(la, b)]) << (16 * exp_lane(a, b));
                    logic [7:0]  es = 8'(3 << (2 * exp_lane(a, b)));
                    n_chk++; if (wb_data[b] !== ed || wb_strb[b] !== es || wb_last[b] !== (b == int'(l))) begin
                        n_fail++; $display("FAIL rnd_wr_beat it %0d b %0d: got %h/%h/%b want %h/%h/%b", it, b, wb_data[b], wb_strb[b], wb_last[b], ed, es, b == int'(l));
                    end
                end
                n_chk++; if (got_done != 1 || got_err !== (resp != 2'b00)) begin
                    n_fail++; $display("FAIL rnd_wr_err it %0d: got done=%0d err=%b want 1/%b", it, got_done, got_err, resp != 2'b00);
                end
            end else begin
                rl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : int'(l);
                bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
                n   = ((rl < int'(l)) ? rl : int'(l)) + 1;
                eerr = (rl != int'(l)) || (bad >= 0 && bad < n);
                drive_read(a, l, la, 1'b1, rl, bad);
                n_chk++; if (timeout != 0 || sk_data.size() != n) begin
                    n_fail++; $display("FAIL rnd_rd_writes it %0d: got %0d timeout=%0d want %0d", it, sk_data.size(), timeout, n);
                end
                for (int b = 0; b < sk_data.size() && b < n && b < rsent.size(); b++) begin
                    logic [63:0] w = rsent[b];
                    logic [15:0] ed = 16'(w >> (16 * exp_lane(a, b)));
                    n_chk++; if (sk_addr[b] !== exp_laddr(la, b) || sk_data[b] !== ed) begin
                        n_fail++; $display("FAIL rnd_rd_beat it %0d b %0d: got %h@%h want %h@%h", it, b, sk_data[b], sk_addr[b], ed, exp_laddr(la, b));
                    end
                end
                n_chk++; if (got_done != 1 || got_err !== eerr) begin
                    n_fail++; $display("FAIL rnd_rd_err it %0d: got done=%0d err=%b want 1/%b", it, got_done, got_err, eerr);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_stall();
        test_errors();
        test_reset_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
